fmul_arbiter: RTL
=================

FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one 32-bit floating-point multiplier.
REQ-002 The block SHALL have parameter MUL_LAT, default 4: fixed multiplier latency in cycles (edge operands are driven -> edge result is valid on mul_c).
REQ-003 Port clk  input  1: single clock, rising-edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port en  input  1: 1 = accept requests; 0 = stop issuing and drain.
REQ-006 Port req_valid  input  NREQ: per-requester operand valid.
REQ-007 Port req_a, req_b  input  32*NREQ: packed IEEE-754 single operands; requester i uses bits [32i+31:32i].
REQ-008 Port req_ready  output  NREQ: one-hot grant; handshake = req_valid[i] & req_ready[i] at a rising edge.
REQ-009 Port mul_a, mul_b  output  32: registered operands to the multiplier.
REQ-010 Port mul_c  input  32; mul_ov  input  1: multiplier result and overflow.
REQ-011 Port rsp_valid  output  NREQ: one-hot result strobe, one cycle, no back-pressure.
REQ-012 Port rsp_c  output  32; rsp_ov  output  1: result and overflow for the strobed requester.
REQ-013 Port busy  output  1: high while state is not IDLE or any tag is in flight.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-015 Transitions: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when the tag pipe is empty; DRAIN->RUN when en=1.
REQ-016 req_ready SHALL be all-zero outside RUN.
REQ-017 In RUN, req_ready SHALL be combinational: it grants the first req_valid bit found scanning from rr_ptr upward, modulo NREQ; at most one grant per cycle.
REQ-018 On a handshake from requester g, rr_ptr SHALL become (g+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-019 On a handshake at edge E, mul_a/mul_b SHALL load that requester's operands at E; otherwise they SHALL hold.
REQ-020 A tag pipe MUL_LAT deep (valid bit + log2(NREQ)-bit id) SHALL shift every cycle; a bubble enters when there is no handshake.
REQ-021 rsp_valid[id] SHALL be 1 in the cycle after edge E+MUL_LAT; rsp_c/rsp_ov SHALL be mul_c/mul_ov passed through combinationally; total latency = MUL_LAT cycles.
REQ-022 Back-to-back handshakes SHALL produce back-to-back responses in issue order, with throughput 1 per cycle.
REQ-023 en falling while requests are in flight SHALL NOT drop them; all in-flight tags SHALL complete in DRAIN.
REQ-024 rsp_c/rsp_ov SHALL be don't-care when rsp_valid=0.

Reset
REQ-025 Assertion of rst SHALL asynchronously force: state=IDLE, rr_ptr=0, tag pipe all invalid, mul_a=mul_b=0, rsp_valid=0, busy=0.
REQ-026 Reset mid-operation SHALL discard in-flight results; no rsp_valid SHALL follow for them after reset release.

Configuration
REQ-027 With FMUL_ARB_STATS_EN defined, the block SHALL add output stat_grants (16*NREQ): per-requester grant counters that saturate at 16'hFFFF and are cleared by reset.
REQ-028 With FMUL_ARB_STATS_EN undefined, stat_grants and the counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package fmul_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the FP_W=32 constant.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_grant (inputs req, ptr; output one-hot grant).
REQ-031 The bench SHALL pair the block with a MUL_LAT-cycle multiplier model.

Verification
REQ-032 en=1 with only req_valid[0], a=3F800000, b=40000000 -> req_ready=0001; rsp_valid=0001 four cycles later with rsp_c=40000000 and rsp_ov=0.
REQ-033 All four valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; responses in the same order with no gaps.
REQ-034 Requests from 1 and 3 only, rr_ptr=2 -> requester 3 is granted first, then 1.
REQ-035 Three issues, then en=0 -> state DRAIN, req_ready=0, all three responses delivered, then IDLE with busy=0.
REQ-036 rst pulsed low two cycles after an issue -> no rsp_valid afterwards; all outputs at reset values.
REQ-037 With FMUL_ARB_STATS_EN defined, 70000 grants to requester 2 -> its stat_grants field reads FFFF.

Source files
------------

// File: rtl/fmul_arb_pkg.sv
// fmul_arb_pkg: FSM encoding and operand width shared by the fmul_arbiter slice.
package fmul_arb_pkg;
    localparam int FP_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/fmul_arbiter_rr_grant.sv
// rr_grant: one-hot grant to the first set req bit found scanning upward from ptr, wrapping at N.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);
    always_comb begin
        grant = '0;
        // Walk offsets from farthest to nearest so the nearest requester overwrites last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) grant = N'(1) << ((int'(ptr) + k) % N);
        end
    end
endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one pipelined FP multiplier among NREQ requesters.
// Defining FMUL_ARB_STATS_EN adds saturating per-requester grant counters on stat_grants.
module fmul_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [FP_W*NREQ-1:0] req_a,
    input  logic [FP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [FP_W-1:0]      mul_a,
    output logic [FP_W-1:0]      mul_b,
    input  logic [FP_W-1:0]      mul_c,
    input  logic                 mul_ov,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_c,
    output logic                 rsp_ov,
    output logic                 busy
`ifdef FMUL_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0]   stat_grants
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, gid;
    logic [FP_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [NREQ-1:0] grant;
    logic            hs;
    // Stage 0 travels with the operand register, so stage MUL_LAT lines up with mul_c.
    logic [MUL_LAT:0] vld_q;
    logic [IW-1:0]    id_q [MUL_LAT+1];

    rr_grant #(.N(NREQ), .IW(IW)) u_grant (.req(req_valid), .ptr(ptr_q), .grant(grant));

    always_comb begin
        gid = '0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) gid = IW'(i);
    end

    assign hs      = |(req_valid & req_ready);
    assign ptr_d   = hs ? ((gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1) : ptr_q;
    assign mul_a_d = hs ? req_a[gid * FP_W +: FP_W] : mul_a_q;
    assign mul_b_d = hs ? req_b[gid * FP_W +: FP_W] : mul_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en ? RUN : IDLE;
            RUN:     state_d = en ? RUN : DRAIN;
            DRAIN:   state_d = en ? RUN : ((|vld_q) ? DRAIN : IDLE);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == RUN) ? grant : '0;
        busy      = (state_q != IDLE) || (|vld_q);
        rsp_valid = vld_q[MUL_LAT] ? NREQ'(1) << id_q[MUL_LAT] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            vld_q   <= '0;
            for (int k = 0; k <= MUL_LAT; k++) id_q[k] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            vld_q   <= {vld_q[MUL_LAT-1:0], hs};
            id_q[0] <= gid;
            for (int k = 1; k <= MUL_LAT; k++) id_q[k] <= id_q[k-1];
        end
    end

    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign rsp_c  = mul_c;
    assign rsp_ov = mul_ov;

`ifdef FMUL_ARB_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt_q <= '0;
            else if (req_valid[g] && req_ready[g] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
        end
        assign stat_grants[16*g +: 16] = cnt_q;
    end
`endif
endmodule
